// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus receive path: FSM encoding,
// start/end pulse counts and datapath widths.
package maple_pkg;

  localparam int MAPLE_BYTE_W  = 8;
  localparam int MAPLE_PULSE_W = 3;

  localparam logic [MAPLE_PULSE_W-1:0] MAPLE_START_PULSES = 3'd4;
  localparam logic [MAPLE_PULSE_W-1:0] MAPLE_END_PULSES   = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_START_CNT,
    ST_DATA_A,
    ST_DATA_B,
    ST_END_CNT
  } maple_state_t;

endpackage

// File: rtl/maple_in_sync.sv
// Two-flop synchronizer with registered edge detect for one Maple line.
// All stages preset to 1 so an idle-high bus produces no events out of reset.
module maple_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic stable;

  // level and the edge flags update together, so a fall event is always
  // seen alongside the new (low) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      stable <= 1'b1;
      level  <= 1'b1;
      fall   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= line_in;
      stable <= meta;
      level  <= stable;
      fall   <= level & ~stable;
      rise   <= ~level & stable;
    end
  end

endmodule

// File: rtl/maple_in.sv
// Maple bus receiver: start/end pattern detection and MSB-first byte decode.
// Optional running XOR check enabled by defining MAPLE_IN_CHECKSUM_EN.
module maple_in
  import maple_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       arm,
  input  logic       abort,
  input  logic       fifo_full,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       status_active,
  output logic       status_done,
  output logic       err_frame,
  output logic       err_overflow,
  output logic       err_timeout,
  output logic [7:0] byte_count,
  output logic       checksum_ok
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  logic p1_level, p1_fall, p1_rise;
  logic p5_level, p5_fall, p5_rise;

  maple_in_sync u_sync_p1 (
    .clk(clk), .rst(rst), .line_in(in_p1),
    .level(p1_level), .fall(p1_fall), .rise(p1_rise)
  );

  maple_in_sync u_sync_p5 (
    .clk(clk), .rst(rst), .line_in(in_p5),
    .level(p5_level), .fall(p5_fall), .rise(p5_rise)
  );

  maple_state_t             state;
  logic [MAPLE_PULSE_W-1:0] pulse_cnt;
  logic [2:0]               bit_cnt;
  logic [MAPLE_BYTE_W-1:0]  shift_reg;
  logic [TO_W-1:0]          to_cnt;
`ifdef MAPLE_IN_CHECKSUM_EN
  logic [MAPLE_BYTE_W-1:0]  xor_acc;
`endif

  logic                    in_frame;
  logic                    any_edge;
  logic                    both_fall;
  logic                    timeout_hit;
  logic                    take_bit;
  logic                    bit_in;
  logic [MAPLE_BYTE_W-1:0] new_byte;

  // In DATA_A the clock is p1 and data rides on p5; DATA_B swaps the roles
  assign in_frame    = (state == ST_START_CNT) || (state == ST_DATA_A) ||
                       (state == ST_DATA_B) || (state == ST_END_CNT);
  assign any_edge    = p1_fall | p1_rise | p5_fall | p5_rise;
  assign both_fall   = p1_fall & p5_fall;
  assign timeout_hit = tick && !any_edge && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
  assign take_bit    = !both_fall && (((state == ST_DATA_A) && p1_fall) ||
                                      ((state == ST_DATA_B) && p5_fall));
  assign bit_in      = (state == ST_DATA_A) ? p5_level : p1_level;
  assign new_byte    = {shift_reg[MAPLE_BYTE_W-2:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      pulse_cnt     <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      to_cnt        <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      status_active <= 1'b0;
      status_done   <= 1'b0;
      err_frame     <= 1'b0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
      byte_count    <= '0;
`ifdef MAPLE_IN_CHECKSUM_EN
      xor_acc       <= '0;
      checksum_ok   <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (abort) begin
        state         <= ST_IDLE;
        status_active <= 1'b0;
      end else if (arm) begin
        state         <= ST_WAIT_START;
        pulse_cnt     <= '0;
        bit_cnt       <= '0;
        shift_reg     <= '0;
        to_cnt        <= '0;
        status_active <= 1'b0;
        status_done   <= 1'b0;
        err_frame     <= 1'b0;
        err_overflow  <= 1'b0;
        err_timeout   <= 1'b0;
        byte_count    <= '0;
`ifdef MAPLE_IN_CHECKSUM_EN
        xor_acc       <= '0;
        checksum_ok   <= 1'b0;
`endif
      end else begin
        if (!in_frame || any_edge) to_cnt <= '0;
        else if (tick)             to_cnt <= to_cnt + 1'b1;

        if (state == ST_WAIT_START) begin
          if (p1_fall && p5_level) begin
            state     <= ST_START_CNT;
            pulse_cnt <= '0;
          end
        end else if (in_frame && (both_fall || timeout_hit)) begin
          // Both error aborts end the frame and report it as done
          state         <= ST_IDLE;
          status_active <= 1'b0;
          status_done   <= 1'b1;
          if (both_fall) err_frame   <= 1'b1;
          else           err_timeout <= 1'b1;
`ifdef MAPLE_IN_CHECKSUM_EN
          checksum_ok   <= 1'b0;
`endif
        end else begin
          case (state)
            ST_START_CNT: begin
              if (p5_fall && pulse_cnt != '1) pulse_cnt <= pulse_cnt + 1'b1;
              if (p1_rise) begin
                if (pulse_cnt == MAPLE_START_PULSES) begin
                  state         <= ST_DATA_A;
                  status_active <= 1'b1;
                end else begin
                  state <= ST_WAIT_START;
                end
              end
            end
            ST_DATA_A: begin
              if (p1_fall) begin
                state <= ST_DATA_B;
              end else if (p5_fall && p1_level) begin
                state     <= ST_END_CNT;
                pulse_cnt <= '0;
              end
            end
            ST_DATA_B: begin
              if (p5_fall) state <= ST_DATA_A;
            end
            ST_END_CNT: begin
              if (p1_fall && pulse_cnt != '1) pulse_cnt <= pulse_cnt + 1'b1;
              if (p5_rise) begin
                state         <= ST_IDLE;
                status_active <= 1'b0;
                status_done   <= 1'b1;
                if ((pulse_cnt != MAPLE_END_PULSES) || (bit_cnt != 3'd0))
                  err_frame <= 1'b1;
`ifdef MAPLE_IN_CHECKSUM_EN
                checksum_ok <= (pulse_cnt == MAPLE_END_PULSES) && (bit_cnt == 3'd0) &&
                               (byte_count != 8'd0) && (xor_acc == '0);
`endif
              end
            end
            default: ;
          endcase
        end

        // Dropped bytes still count and still enter the XOR
        if (take_bit) begin
          shift_reg <= new_byte;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            data <= new_byte;
            if (byte_count != 8'hFF) byte_count <= byte_count + 1'b1;
            if (fifo_full) err_overflow <= 1'b1;
            else           data_valid   <= 1'b1;
`ifdef MAPLE_IN_CHECKSUM_EN
            xor_acc <= xor_acc ^ new_byte;
`endif
          end
        end
      end
    end
  end

`ifndef MAPLE_IN_CHECKSUM_EN
  assign checksum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_maple_in.sv
// Directed bench for maple_in: table of whole frames plus hand-written
// sequences for short start, timeout, abort and byte_count saturation.
module tb_maple_in;

`ifdef MAPLE_IN_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       in_p1;
  logic       in_p5;
  logic       arm;
  logic       abort;
  logic       fifo_full;
  logic [7:0] data;
  logic       data_valid;
  logic       status_active;
  logic       status_done;
  logic       err_frame;
  logic       err_overflow;
  logic       err_timeout;
  logic [7:0] byte_count;
  logic       checksum_ok;

  always #5 clk = ~clk;

  maple_in #(.TIMEOUT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .in_p1(in_p1), .in_p5(in_p5),
    .arm(arm), .abort(abort), .fifo_full(fifo_full),
    .data(data), .data_valid(data_valid),
    .status_active(status_active), .status_done(status_done),
    .err_frame(err_frame), .err_overflow(err_overflow), .err_timeout(err_timeout),
    .byte_count(byte_count), .checksum_ok(checksum_ok)
  );

  typedef struct {
    logic [3:0][7:0] bytes;
    int              nbytes;
    int              extra;
    logic [3:0]      full_mask;
    int              exp_npush;
    logic [3:0][7:0] exp_push;
    logic [7:0]      exp_count;
    logic            exp_frame;
    logic            exp_over;
    logic            exp_cks;
  } vec_t;

  vec_t       vecs[5];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pushes[$];
  bit         phase_a;

  // Record every push the DUT makes, sampled away from the active edge
  always @(negedge clk) if (!rst && data_valid) pushes.push_back(data);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setLines(input logic p1, input logic p5);
    in_p1 = p1;
    in_p5 = p5;
    waitClk(4);
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    waitClk(1);
    arm = 1'b0;
    waitClk(1);
  endtask

  task automatic sendStart(input int n);
    setLines(1'b1, 1'b1);
    setLines(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      setLines(1'b0, 1'b0);
      if (i < n - 1) setLines(1'b0, 1'b1);
    end
    setLines(1'b1, 1'b0);
    phase_a = 1'b1;
  endtask

  // Data lines only ever rise while being set up, so a bit never looks like an end pattern
  task automatic sendBit(input logic b);
    if (phase_a) begin
      setLines(1'b1, b);
      setLines(1'b0, b);
    end else begin
      setLines(b, 1'b1);
      setLines(b, 1'b0);
    end
    phase_a = ~phase_a;
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
  endtask

  task automatic sendEnd();
    setLines(1'b1, 1'b1);
    setLines(1'b1, 1'b0);
    setLines(1'b0, 1'b0);
    setLines(1'b1, 1'b0);
    setLines(1'b0, 1'b0);
    setLines(1'b1, 1'b0);
    setLines(1'b1, 1'b1);
  endtask

  task automatic checkPushes(input string name, input int n, input logic [3:0][7:0] exp);
    checkOutput({name, " push count"}, pushes.size(), n);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s push %0d", name, i),
                  (i < pushes.size()) ? {24'd0, pushes[i]} : 32'hDEAD, {24'd0, exp[i]});
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v = vecs[idx];
    string name = $sformatf("vec%0d", idx);
    pushes.delete();
    pulseArm();
    sendStart(4);
    for (int i = 0; i < v.nbytes; i++) begin
      fifo_full = v.full_mask[i];
      sendByte(v.bytes[i]);
      fifo_full = 1'b0;
    end
    for (int i = 0; i < v.extra; i++) sendBit((i % 2) == 0);
    sendEnd();
    waitClk(2);
    checkPushes(name, v.exp_npush, v.exp_push);
    checkOutput({name, " byte_count"}, byte_count, v.exp_count);
    checkOutput({name, " status_done"}, status_done, 1);
    checkOutput({name, " status_active"}, status_active, 0);
    checkOutput({name, " err_frame"}, err_frame, v.exp_frame);
    checkOutput({name, " err_overflow"}, err_overflow, v.exp_over);
    checkOutput({name, " err_timeout"}, err_timeout, 0);
    checkOutput({name, " checksum_ok"}, checksum_ok, CKS_EN & v.exp_cks);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{bytes: {8'h00, 8'h00, 8'h3C, 8'hA5}, nbytes: 2, extra: 0, full_mask: 4'b0000,
                exp_npush: 2, exp_push: {8'h00, 8'h00, 8'h3C, 8'hA5}, exp_count: 8'd2,
                exp_frame: 1'b0, exp_over: 1'b0, exp_cks: 1'b0};
    vecs[1] = '{bytes: {8'h00, 8'h00, 8'h00, 8'h12}, nbytes: 1, extra: 4, full_mask: 4'b0000,
                exp_npush: 1, exp_push: {8'h00, 8'h00, 8'h00, 8'h12}, exp_count: 8'd1,
                exp_frame: 1'b1, exp_over: 1'b0, exp_cks: 1'b0};
    vecs[2] = '{bytes: {8'h00, 8'h33, 8'h22, 8'h11}, nbytes: 3, extra: 0, full_mask: 4'b0010,
                exp_npush: 2, exp_push: {8'h00, 8'h00, 8'h33, 8'h11}, exp_count: 8'd3,
                exp_frame: 1'b0, exp_over: 1'b1, exp_cks: 1'b1};
    vecs[3] = '{bytes: {8'h00, 8'h55, 8'h0F, 8'h5A}, nbytes: 3, extra: 0, full_mask: 4'b0000,
                exp_npush: 3, exp_push: {8'h00, 8'h55, 8'h0F, 8'h5A}, exp_count: 8'd3,
                exp_frame: 1'b0, exp_over: 1'b0, exp_cks: 1'b1};
    vecs[4] = '{bytes: {8'h00, 8'h54, 8'h0F, 8'h5A}, nbytes: 3, extra: 0, full_mask: 4'b0000,
                exp_npush: 3, exp_push: {8'h00, 8'h54, 8'h0F, 8'h5A}, exp_count: 8'd3,
                exp_frame: 1'b0, exp_over: 1'b0, exp_cks: 1'b0};

    rst = 1'b1; tick = 1'b0; in_p1 = 1'b1; in_p5 = 1'b1;
    arm = 1'b0; abort = 1'b0; fifo_full = 1'b0; phase_a = 1'b1;
    waitClk(3);
    checkOutput("reset data", data, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset status_active", status_active, 0);
    checkOutput("reset status_done", status_done, 0);
    checkOutput("reset errors", {err_frame, err_overflow, err_timeout}, 0);
    checkOutput("reset byte_count", byte_count, 0);
    checkOutput("reset checksum_ok", checksum_ok, 0);
    rst = 1'b0;
    waitClk(4);

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // Short start pattern is dropped silently, the following frame is received
    pushes.delete();
    pulseArm();
    checkOutput("arm clears byte_count", byte_count, 0);
    checkOutput("arm clears status_done", status_done, 0);
    sendStart(3);
    checkOutput("short start status_active", status_active, 0);
    checkOutput("short start err_frame", err_frame, 0);
    sendStart(4);
    checkOutput("retry status_active", status_active, 1);
    sendByte(8'h01);
    sendEnd();
    waitClk(2);
    checkPushes("retry", 1, {8'h00, 8'h00, 8'h00, 8'h01});
    checkOutput("retry byte_count", byte_count, 1);
    checkOutput("retry status_done", status_done, 1);
    checkOutput("retry errors", {err_frame, err_overflow, err_timeout}, 0);

    // Lines frozen mid-byte; the fourth tick aborts the frame
    pulseArm();
    sendStart(4);
    sendBit(1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; waitClk(1);
      tick = 1'b0; waitClk(1);
    end
    checkOutput("timeout after 3 ticks", err_timeout, 0);
    checkOutput("timeout still active", status_active, 1);
    tick = 1'b1; waitClk(1);
    tick = 1'b0; waitClk(2);
    checkOutput("timeout err_timeout", err_timeout, 1);
    checkOutput("timeout status_done", status_done, 1);
    checkOutput("timeout status_active", status_active, 0);
    checkOutput("timeout err_frame", err_frame, 0);
    sendStart(4);
    checkOutput("idle ignores start", status_active, 0);

    // Abort mid-byte holds the count and issues no push for the partial byte
    pushes.delete();
    pulseArm();
    sendStart(4);
    sendByte(8'h77);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    abort = 1'b1; waitClk(1);
    abort = 1'b0; waitClk(2);
    checkOutput("abort status_active", status_active, 0);
    checkOutput("abort status_done", status_done, 0);
    checkOutput("abort byte_count", byte_count, 1);
    checkOutput("abort push count", pushes.size(), 1);
    setLines(1'b1, 1'b1);

    // 256 bytes: count saturates at 255, every byte still pushed, XOR of 0..255 is 0
    pushes.delete();
    pulseArm();
    sendStart(4);
    for (int i = 0; i < 256; i++) sendByte(8'(i));
    sendEnd();
    waitClk(2);
    checkOutput("sat byte_count", byte_count, 255);
    checkOutput("sat push count", pushes.size(), 256);
    checkOutput("sat last push", (pushes.size() > 0) ? {24'd0, pushes[$]} : 32'hDEAD, 32'hFF);
    checkOutput("sat status_done", status_done, 1);
    checkOutput("sat errors", {err_frame, err_overflow, err_timeout}, 0);
    checkOutput("sat checksum_ok", checksum_ok, CKS_EN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
